inside_search_ctrl: RTL and testbench
=====================================

Name: inside_search_ctrl

Overview:
Sequential set-membership ("inside") lookup engine. It holds a small writable table of candidate values with per-entry enable bits, and accepts one search key at a time through a valid/ready request port. It scans the table one entry per clock, stops at the first match, and returns hit/index on a valid/ready response port. It serves as the shared, configurable controller for membership checks elsewhere in the design.

Parameters:
WIDTH, 8, bit width of keys and table entries
DEPTH, 4, number of table entries (2..256)
IDX_W, 2, index width; must equal clog2(DEPTH), minimum 1

Ports:
CLK  input  1  clock; all state changes on rising edge
RST_N  input  1  reset, synchronous, active-low
CFG_WE  input  1  table write strobe
CFG_ADDR  input  IDX_W  table entry to write
CFG_DATA  input  WIDTH  value to store
CFG_EN  input  1  enable bit stored with the entry (0 = entry never matches)
CFG_READY  output  1  high when a write will be accepted (state IDLE)
REQ_VALID  input  1  search request valid
REQ_READY  output  1  high when a request will be accepted (state IDLE)
REQ_DATA  input  WIDTH  search key
RESP_VALID  output  1  result valid
RESP_READY  input  1  consumer accepts result
RESP_HIT  output  1  1 = key found in an enabled entry
RESP_IDX  output  IDX_W  index of the first matching entry; 0 on miss
BUSY  output  1  high in SEARCH or RESP

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low. Port names are CLK and RST_N.
- Reset (RST_N=0 at an edge):
  - state goes to IDLE; all table values and enable bits clear to 0.
  - RESP_VALID=0, RESP_HIT=0, RESP_IDX=0, BUSY=0.
  - REQ_READY and CFG_READY read 0 while RST_N=0.
- Reset mid-operation: an in-flight search or pending response is discarded; no response is ever issued for it.
- FSM states: IDLE, SEARCH, RESP.
  - IDLE:
    - REQ_READY=1, CFG_READY=1.
    - On REQ_VALID: latch REQ_DATA into the key register, set ptr=0, go to SEARCH.
  - SEARCH:
    - Each cycle, compare key with table[ptr]; the entry is eligible only if its enable bit is 1.
    - Match: latch HIT=1 and IDX=ptr, go to RESP.
    - No match with ptr==DEPTH-1: latch HIT=0 and IDX=0, go to RESP.
    - Otherwise: ptr=ptr+1.
  - RESP:
    - RESP_VALID=1; RESP_HIT and RESP_IDX are held stable until the handshake.
    - On RESP_READY: go to IDLE.
- Handshakes:
  - REQ_READY=0 and CFG_READY=0 outside IDLE.
  - At most one request is outstanding at a time.
  - After a response handshake there is a minimum of one IDLE cycle before the next request can be accepted.
- Latency: with request accepted at edge n, a match at index k gives RESP_VALID=1 after edge n+1+k. A miss gives RESP_VALID=1 after edge n+DEPTH.
- Config writes:
  - Applied at an edge only when CFG_WE=1 and state is IDLE; ignored in SEARCH and RESP (no queuing).
  - CFG_ADDR >= DEPTH is ignored (non-power-of-2 DEPTH).
  - A write in the same cycle as a request accept is applied at that edge, so the search sees the new value.
- Duplicates: the lowest matching index wins.
- Disabled entries never match, even when their value equals the key (including key 0 against a cleared table).
- Arithmetic: the comparison is a full WIDTH-bit equality. ptr is IDX_W bits wide and never wraps, because the scan ends at DEPTH-1.
- Response outputs are registered; there is no combinational path from REQ_* to RESP_*.

Test Plan:
- Reset then table load: write 100/110/120/130 to entries 0..3 with EN=1, then search 120 -> RESP_HIT=1, RESP_IDX=2, RESP_VALID high 3 cycles after the accept edge.
- Miss and timing: search 115 -> RESP_HIT=0, RESP_IDX=0, RESP_VALID exactly DEPTH=4 cycles after accept; search 100 -> hit, IDX=0 after 1 cycle.
- Enable and duplicates: disable entry 1, then search 110 -> miss. Write 120 into entry 0, then search 120 -> IDX=0 (lowest index wins).
- Backpressure: hold RESP_READY=0 for 5 cycles -> RESP_VALID/HIT/IDX stay stable, REQ_READY=0, CFG_WE ignored (table unchanged). Then RESP_READY=1 -> one IDLE cycle, then the next request is accepted.
- Same-cycle write and accept: in IDLE, write 77 to entry 3 together with REQ key 77 -> hit, IDX=3.
- Reset mid-search: drive RST_N=0 during SEARCH -> no RESP_VALID ever for that request. After reset, searching 0 -> miss (table cleared, all entries disabled).

Source files
------------

// File: rtl/inside_search_ctrl.sv
// inside_search_ctrl: sequential set-membership lookup engine.
// A small writable table of (value, enable) entries is scanned one entry
// per clock for a search key; the first enabled entry whose value equals
// the key is reported as a hit together with its index.
//
// Handshake rule for both the request and response ports: a transfer
// happens at a rising CLK edge where valid and ready are both high. The
// producer holds valid and its payload stable until that edge. The ready
// outputs of this block do not depend on the matching valid input.
//
// IDX_W must equal clog2(DEPTH) (minimum 1); DEPTH may be 2..256.
module inside_search_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CFG_WE,
  input  logic [IDX_W-1:0] CFG_ADDR,
  input  logic [WIDTH-1:0] CFG_DATA,
  input  logic             CFG_EN,
  output logic             CFG_READY,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_DATA,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic             RESP_HIT,
  output logic [IDX_W-1:0] RESP_IDX,
  output logic             BUSY,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   key, key_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [WIDTH-1:0]   tbl_val [DEPTH];
  logic [DEPTH-1:0]   tbl_en;

  logic               match;
  logic               last;
  logic               addr_ok;
  logic               cfg_apply;

  // Current-entry comparison; a disabled entry never matches.
  always_comb begin
    match     = tbl_en[ptr] && (tbl_val[ptr] == key);
    last      = (ptr == IDX_W'(DEPTH - 1));
    addr_ok   = (32'(CFG_ADDR) < 32'(DEPTH));
    cfg_apply = (state == IDLE) && CFG_WE && addr_ok;
  end

  // Next-state and next-datapath logic for the scan controller.
  always_comb begin
    state_d = state;
    key_d   = key;
    ptr_d   = ptr;
    hit_d   = hit_q;
    idx_d   = idx_q;
    case (state)
      IDLE: begin
        if (REQ_VALID) begin
          key_d   = REQ_DATA;
          ptr_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (match) begin
          hit_d   = 1'b1;
          idx_d   = ptr;
          state_d = RESP;
        end else if (last) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = RESP;
        end else begin
          ptr_d = ptr + IDX_W'(1);
        end
      end
      RESP: begin
        if (RESP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight search.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      key   <= '0;
      ptr   <= '0;
      hit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state <= state_d;
      key   <= key_d;
      ptr   <= ptr_d;
      hit_q <= hit_d;
      idx_q <= idx_d;
    end
  end

  // Table storage: writes land only while idle, so a write issued in the
  // same cycle as a request accept is visible to that search.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_val[i] <= '0;
      end
      tbl_en <= '0;
    end else if (cfg_apply) begin
      tbl_val[CFG_ADDR] <= CFG_DATA;
      tbl_en[CFG_ADDR]  <= CFG_EN;
    end
  end

  // Output decode: responses come straight from registers.
  always_comb begin
    REQ_READY  = (state == IDLE) && RST_N;
    CFG_READY  = (state == IDLE) && RST_N;
    RESP_VALID = (state == RESP);
    RESP_HIT   = hit_q;
    RESP_IDX   = idx_q;
    BUSY       = (state == SEARCH) || (state == RESP);
    DBG_STATE  = state;
  end

endmodule

// File: tb/tb_inside_search_ctrl.sv
// Testbench for inside_search_ctrl: directed scenarios plus a randomized
// phase, checked by a scoreboard against a table-level reference model.
module tb_inside_search_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int EW    = 32 + 1 + IDX_W;

  logic             CLK;
  logic             RST_N;
  logic             CFG_WE;
  logic [IDX_W-1:0] CFG_ADDR;
  logic [WIDTH-1:0] CFG_DATA;
  logic             CFG_EN;
  logic             CFG_READY;
  logic             REQ_VALID;
  logic             REQ_READY;
  logic [WIDTH-1:0] REQ_DATA;
  logic             RESP_VALID;
  logic             RESP_READY;
  logic             RESP_HIT;
  logic [IDX_W-1:0] RESP_IDX;
  logic             BUSY;
  logic [1:0]       DBG_STATE;

  inside_search_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .CFG_EN(CFG_EN), .CFG_READY(CFG_READY),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY),
    .RESP_HIT(RESP_HIT), .RESP_IDX(RESP_IDX),
    .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  // ---------------- counters / check ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: actual timeout required event (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_val [DEPTH];
  logic [DEPTH-1:0] m_en;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_val[i] = '0;
    m_en = '0;
  endtask

  task automatic model_write(input int addr, input logic [WIDTH-1:0] data, input logic en);
    if (addr < DEPTH) begin
      m_val[addr] = data;
      m_en[addr]  = en;
    end
  endtask

  // Expected {response cycle, hit, idx} for a key accepted at cycle acc.
  function automatic logic [EW-1:0] expect_for(input logic [WIDTH-1:0] k, input int acc);
    int found;
    found = -1;
    for (int i = 0; i < DEPTH; i++)
      if (found < 0 && m_en[i] && m_val[i] == k) found = i;
    if (found >= 0) return {32'(acc + found + 1), 1'b1, IDX_W'(found)};
    return {32'(acc + DEPTH), 1'b0, IDX_W'(0)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0]    exp_q [$];
  logic             prev_valid = 1'b0;
  logic             h_hit;
  logic [IDX_W-1:0] h_idx;

  // A new response is a 0->1 edge of RESP_VALID: every handshake returns
  // through IDLE, so back-to-back responses always have a gap.
  always @(negedge CLK) begin
    logic [EW-1:0] e;
    if (!RST_N) begin
      prev_valid = 1'b0;
    end else begin
      if (RESP_VALID && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: actual RESP_VALID=1 required no response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
          check("resp_hit", 64'(RESP_HIT), 64'(e[IDX_W]));
          check("resp_idx", 64'(RESP_IDX), 64'(e[IDX_W-1:0]));
          check("req_ready_in_resp", 64'(REQ_READY), 64'(0));
        end
        h_hit = RESP_HIT;
        h_idx = RESP_IDX;
      end else if (RESP_VALID) begin
        check("hold_hit", 64'(RESP_HIT), 64'(h_hit));
        check("hold_idx", 64'(RESP_IDX), 64'(h_idx));
      end
      prev_valid = RESP_VALID;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (!REQ_READY) begin
      @(negedge CLK);
      n++;
      if (n > 200) begin
        fail_now("wait_idle");
        return;
      end
    end
  endtask

  task automatic cfg_write(input int addr, input logic [WIDTH-1:0] data, input logic en);
    wait_idle();
    CFG_WE = 1'b1; CFG_ADDR = IDX_W'(addr); CFG_DATA = data; CFG_EN = en;
    @(posedge CLK); #1;
    CFG_WE = 1'b0;
    model_write(addr, data, en);
  endtask

  task automatic search(input logic [WIDTH-1:0] k, input logic wr, input int addr,
                        input logic [WIDTH-1:0] data, input logic en);
    wait_idle();
    REQ_VALID = 1'b1; REQ_DATA = k;
    if (wr) begin
      CFG_WE = 1'b1; CFG_ADDR = IDX_W'(addr); CFG_DATA = data; CFG_EN = en;
    end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    CFG_WE    = 1'b0;
    if (wr) model_write(addr, data, en);
    exp_q.push_back(expect_for(k, cyc));
  endtask

  task automatic wait_drain(input logic bp);
    int n = 0;
    while (exp_q.size() != 0 || RESP_VALID) begin
      @(negedge CLK);
      #2;
      if (bp) RESP_READY = 1'($urandom_range(0, 1));
      n++;
      if (n > 300) begin
        fail_now("wait_drain");
        exp_q.delete();
        break;
      end
    end
    RESP_READY = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen;
    RST_N = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0; CFG_EN = 1'b0;
    REQ_VALID = 1'b0; REQ_DATA = '0; RESP_READY = 1'b1;
    model_clear();

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_resp_valid", 64'(RESP_VALID), 64'(0));
    check("rst_resp_hit", 64'(RESP_HIT), 64'(0));
    check("rst_resp_idx", 64'(RESP_IDX), 64'(0));
    check("rst_busy", 64'(BUSY), 64'(0));
    check("rst_req_ready", 64'(REQ_READY), 64'(0));
    check("rst_cfg_ready", 64'(CFG_READY), 64'(0));
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle_req_ready", 64'(REQ_READY), 64'(1));
    check("idle_cfg_ready", 64'(CFG_READY), 64'(1));

    // Table load and basic hits / misses
    for (int i = 0; i < DEPTH; i++) cfg_write(i, WIDTH'(100 + 10 * i), 1'b1);
    search(8'd120, 1'b0, 0, 0, 0); wait_drain(1'b0);
    search(8'd115, 1'b0, 0, 0, 0); wait_drain(1'b0);
    search(8'd100, 1'b0, 0, 0, 0); wait_drain(1'b0);

    // Enable bit and duplicate priority
    cfg_write(1, 8'd110, 1'b0);
    search(8'd110, 1'b0, 0, 0, 0); wait_drain(1'b0);
    cfg_write(0, 8'd120, 1'b1);
    search(8'd120, 1'b0, 0, 0, 0); wait_drain(1'b0);

    // Backpressure: response held, config writes ignored
    RESP_READY = 1'b0;
    search(8'd130, 1'b0, 0, 0, 0);
    begin
      int n = 0;
      while (!RESP_VALID && n < 50) begin @(negedge CLK); n++; end
      if (!RESP_VALID) fail_now("bp_wait_valid");
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_req_ready", 64'(REQ_READY), 64'(0));
      check("bp_cfg_ready", 64'(CFG_READY), 64'(0));
      check("bp_valid", 64'(RESP_VALID), 64'(1));
      CFG_WE = 1'b1; CFG_ADDR = 2'd3; CFG_DATA = 8'd55; CFG_EN = 1'b1;
      @(negedge CLK);
    end
    CFG_WE = 1'b0;
    RESP_READY = 1'b1;
    @(negedge CLK);
    check("post_hs_valid", 64'(RESP_VALID), 64'(0));
    check("post_hs_req_ready", 64'(REQ_READY), 64'(1));
    check("post_hs_busy", 64'(BUSY), 64'(0));
    search(8'd130, 1'b0, 0, 0, 0); wait_drain(1'b0);

    // Same-cycle write and accept
    search(8'd77, 1'b1, 3, 8'd77, 1'b1); wait_drain(1'b0);

    // Randomized traffic over a small value range to force hits and duplicates
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: cfg_write($urandom_range(0, DEPTH - 1), WIDTH'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
        1: begin
          search(WIDTH'($urandom_range(0, 7)), 1'b0, 0, 0, 0);
          wait_drain(1'b1);
        end
        default: begin
          search(WIDTH'($urandom_range(0, 7)), 1'b1, $urandom_range(0, DEPTH - 1),
                 WIDTH'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
          wait_drain(1'b1);
        end
      endcase
    end

    // Reset mid-search: the request must never produce a response
    cfg_write(3, 8'd9, 1'b1);
    search(8'd9, 1'b0, 0, 0, 0);
    @(negedge CLK);
    check("mid_busy", 64'(BUSY), 64'(1));
    RST_N = 1'b0;
    exp_q.delete();
    model_clear();
    @(negedge CLK);
    check("mid_rst_req_ready", 64'(REQ_READY), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (RESP_VALID) seen = 1'b1;
    end
    check("no_resp_after_reset", 64'(seen), 64'(0));
    search(8'd0, 1'b0, 0, 0, 0); wait_drain(1'b0);

    repeat (3) @(negedge CLK);
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
